// File: rtl/cbfp_norm_ctrl_pkg.sv
// Shared types and helpers for the CBFP read-side controller and normaliser.
package cbfp_pkg;

  localparam int CBFP_DATA_WIDTH = 9;
  localparam int CBFP_NUM_IN_OUT = 16;
  localparam int CBFP_REG_DEPTH  = 16;

  // Smallest exponent width able to hold every shift from 0 to data_width-1.
  function automatic int cbfp_exp_width(input int data_width);
    return (data_width > 2) ? $clog2(data_width) : 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM,
    DRAIN
  } cbfp_state_e;

  typedef logic signed [CBFP_DATA_WIDTH-1:0] cbfp_sample_t;

endpackage

// File: rtl/cbfp_norm_ctrl_sign_cnt.sv
// Redundant sign bit count of one signed sample.
// The result is the number of leading bits equal to the sign bit, minus one.
module cbfp_sign_cnt
  import cbfp_pkg::*;
#(
  parameter int DATA_WIDTH = CBFP_DATA_WIDTH,
  parameter int EXP_WIDTH  = cbfp_exp_width(DATA_WIDTH)
) (
  input  logic signed [DATA_WIDTH-1:0] x,
  output logic        [EXP_WIDTH-1:0]  cnt
);

  logic found;

  // Scan from just below the sign bit and stop at the first bit that differs from it.
  always_comb begin
    cnt   = EXP_WIDTH'(DATA_WIDTH - 1);
    found = 1'b0;
    for (int i = DATA_WIDTH - 2; i >= 0; i--) begin
      if (!found && (x[i] != x[DATA_WIDTH-1])) begin
        cnt   = EXP_WIDTH'(DATA_WIDTH - 2 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cbfp_norm_ctrl.sv
// CBFP buffer controller: finds each block's exponent while it is written into
// the delay buffer, then shifts the block by that exponent as it is read back.
module cbfp_norm_ctrl
  import cbfp_pkg::*;
#(
  parameter int DATA_WIDTH = CBFP_DATA_WIDTH,
  parameter int NUM_IN_OUT = CBFP_NUM_IN_OUT,
  parameter int REG_DEPTH  = CBFP_REG_DEPTH,
  parameter int EXP_WIDTH  = cbfp_exp_width(DATA_WIDTH)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         din_valid,
  output logic                         din_ready,
  input  logic signed [DATA_WIDTH-1:0] din_i     [NUM_IN_OUT],
  input  logic signed [DATA_WIDTH-1:0] din_q     [NUM_IN_OUT],
  output logic                         sr_valid,
  output logic                         sr_pop,
  output logic signed [DATA_WIDTH-1:0] sr_din_i  [NUM_IN_OUT],
  output logic signed [DATA_WIDTH-1:0] sr_din_q  [NUM_IN_OUT],
  input  logic signed [DATA_WIDTH-1:0] sr_dout_i [NUM_IN_OUT],
  input  logic signed [DATA_WIDTH-1:0] sr_dout_q [NUM_IN_OUT],
  output logic                         dout_valid,
  output logic signed [DATA_WIDTH-1:0] dout_i    [NUM_IN_OUT],
  output logic signed [DATA_WIDTH-1:0] dout_q    [NUM_IN_OUT],
  output logic        [EXP_WIDTH-1:0]  blk_exp,
  output logic                         dout_last
);

  localparam int                   CNT_W    = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(REG_DEPTH - 1);
  localparam logic [EXP_WIDTH-1:0] EXP_INIT = EXP_WIDTH'(DATA_WIDTH - 1);

  cbfp_state_e                  state_q, state_d;
  logic        [CNT_W-1:0]      cnt_q, cnt_d;
  logic        [EXP_WIDTH-1:0]  acc_exp_q, acc_exp_d;
  logic        [EXP_WIDTH-1:0]  hold_exp_q, hold_exp_d;
  logic                         dout_valid_q, dout_valid_d;
  logic                         dout_last_q, dout_last_d;
  logic        [EXP_WIDTH-1:0]  blk_exp_q, blk_exp_d;
  logic signed [DATA_WIDTH-1:0] dout_i_q [NUM_IN_OUT];
  logic signed [DATA_WIDTH-1:0] dout_i_d [NUM_IN_OUT];
  logic signed [DATA_WIDTH-1:0] dout_q_q [NUM_IN_OUT];
  logic signed [DATA_WIDTH-1:0] dout_q_d [NUM_IN_OUT];

  logic [EXP_WIDTH-1:0] e_i [NUM_IN_OUT];
  logic [EXP_WIDTH-1:0] e_q [NUM_IN_OUT];
  logic [EXP_WIDTH-1:0] beat_min;
  logic [EXP_WIDTH-1:0] acc_min;

  for (genvar g = 0; g < NUM_IN_OUT; g++) begin : g_lane
    cbfp_sign_cnt #(.DATA_WIDTH(DATA_WIDTH), .EXP_WIDTH(EXP_WIDTH)) u_cnt_i (
      .x  (din_i[g]),
      .cnt(e_i[g])
    );
    cbfp_sign_cnt #(.DATA_WIDTH(DATA_WIDTH), .EXP_WIDTH(EXP_WIDTH)) u_cnt_q (
      .x  (din_q[g]),
      .cnt(e_q[g])
    );
  end

  // Minimum exponent over every I and Q lane of the incoming beat, merged with the running block minimum.
  always_comb begin
    beat_min = EXP_INIT;
    for (int l = 0; l < NUM_IN_OUT; l++) begin
      if (e_i[l] < beat_min) beat_min = e_i[l];
      if (e_q[l] < beat_min) beat_min = e_q[l];
    end
    acc_min = (beat_min < acc_exp_q) ? beat_min : acc_exp_q;
  end

  // Drain writes zeros to flush the buffer; otherwise the buffer sees the input lanes directly.
  always_comb begin
    for (int l = 0; l < NUM_IN_OUT; l++) begin
      sr_din_i[l] = (state_q == DRAIN) ? '0 : din_i[l];
      sr_din_q[l] = (state_q == DRAIN) ? '0 : din_q[l];
    end
  end

  // Block sequencing, buffer strobes and exponent handoff at each block boundary.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_exp_d  = acc_exp_q;
    hold_exp_d = hold_exp_q;
    din_ready  = 1'b1;
    sr_valid   = 1'b0;
    sr_pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (din_valid) begin
          sr_valid  = 1'b1;
          acc_exp_d = beat_min;
          cnt_d     = CNT_W'(1);
          state_d   = FILL;
        end
      end
      FILL, STREAM: begin
        if (din_valid) begin
          sr_valid = 1'b1;
          sr_pop   = (state_q == STREAM);
          if (cnt_q == CNT_LAST) begin
            hold_exp_d = acc_min;
            acc_exp_d  = EXP_INIT;
            cnt_d      = '0;
            state_d    = STREAM;
          end else begin
            acc_exp_d = acc_min;
            cnt_d     = cnt_q + CNT_W'(1);
          end
        end else if ((state_q == STREAM) && (cnt_q == '0)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        din_ready = 1'b0;
        sr_valid  = 1'b1;
        sr_pop    = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Normalise whatever is popped this cycle; outputs hold their last value between pops.
  always_comb begin
    dout_valid_d = sr_pop;
    dout_last_d  = sr_pop && (cnt_q == CNT_LAST);
    blk_exp_d    = sr_pop ? hold_exp_q : blk_exp_q;
    for (int l = 0; l < NUM_IN_OUT; l++) begin
      dout_i_d[l] = sr_pop ? (sr_dout_i[l] <<< hold_exp_q) : dout_i_q[l];
      dout_q_d[l] = sr_pop ? (sr_dout_q[l] <<< hold_exp_q) : dout_q_q[l];
    end
  end

  // State, counters, exponents and the output register stage.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      acc_exp_q    <= EXP_INIT;
      hold_exp_q   <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      blk_exp_q    <= '0;
      for (int l = 0; l < NUM_IN_OUT; l++) begin
        dout_i_q[l] <= '0;
        dout_q_q[l] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_exp_q    <= acc_exp_d;
      hold_exp_q   <= hold_exp_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      blk_exp_q    <= blk_exp_d;
      for (int l = 0; l < NUM_IN_OUT; l++) begin
        dout_i_q[l] <= dout_i_d[l];
        dout_q_q[l] <= dout_q_d[l];
      end
    end
  end

  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;
  assign blk_exp    = blk_exp_q;
  assign dout_i     = dout_i_q;
  assign dout_q     = dout_q_q;

endmodule

// File: doc/cbfp_norm_ctrl.md
Name: cbfp_norm_ctrl

Overview:
Controller and normaliser at the read end of the CBFP delay buffer (`cbfp_shift_reg`, 16 lanes x 9-bit I/Q, depth 16).
- Accepts blocks of REG_DEPTH beats of NUM_IN_OUT-lane I/Q samples.
- Computes each block's exponent while the block is written into the buffer.
- Drives the buffer's valid/pop/din.
- Left-shifts the popped samples by that exponent and emits normalised data plus exponent to the next FFT stage.

Parameters:
- DATA_WIDTH, 9, sample width (signed, two's complement).
- NUM_IN_OUT, 16, lanes per beat.
- REG_DEPTH, 16, beats per block; equals buffer depth.
- EXP_WIDTH, 4, block exponent width; must satisfy 2**EXP_WIDTH > DATA_WIDTH-1.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- din_valid  in  1  input beat present.
- din_ready  out  1  beat accepted when din_valid && din_ready.
- din_i, din_q  in  NUM_IN_OUT x DATA_WIDTH signed  input lanes.
- sr_valid  out  1  buffer write strobe.
- sr_pop  out  1  buffer read strobe.
- sr_din_i, sr_din_q  out  NUM_IN_OUT x DATA_WIDTH signed  buffer write data.
- sr_dout_i, sr_dout_q  in  NUM_IN_OUT x DATA_WIDTH signed  buffer read data; combinational, valid while sr_pop.
- dout_valid  out  1  normalised beat present.
- dout_i, dout_q  out  NUM_IN_OUT x DATA_WIDTH signed  normalised lanes.
- blk_exp  out  EXP_WIDTH  shift applied to current dout beat.
- dout_last  out  1  last beat of a block.

Behaviour:
- Reset (rstn=0 at posedge):
  - State goes to IDLE and beat counter to 0.
  - Accumulating exponent resets to DATA_WIDTH-1; held exponent resets to 0.
  - dout_valid, dout_i, dout_q, blk_exp and dout_last reset to 0.
  - Reset mid-block discards all data. rstn also resets the buffer.
- The buffer shifts in on valid (with or without pop). Pop-only is illegal and never driven. sr_pop is asserted only together with sr_valid.
- Per-sample exponent e(x) = number of leading bits equal to the sign bit, minus 1; range 0..DATA_WIDTH-1. x=0 and x=-1 give DATA_WIDTH-1.
- Block exponent = min of e() over all I and Q samples of all REG_DEPTH beats.
- FSM states:
  - IDLE:
    - din_ready=1. An accepted beat goes to FILL with cnt=1, and the accumulating exponent loads that beat's min e.
  - FILL (block 0 written, nothing read):
    - din_ready=1. Each accepted beat drives sr_valid=1, sr_pop=0, sr_din=din, increments cnt and updates acc_exp=min(acc_exp, beat min).
    - On the REG_DEPTH-th beat: hold_exp<=final min, acc_exp re-initialises to DATA_WIDTH-1, cnt<=0, go to STREAM.
  - STREAM (block k+1 written, block k read):
    - din_ready=1. Each accepted beat drives sr_valid=1, sr_pop=1, sr_din=din, and accumulates as in FILL.
    - At a block boundary the exponent handoff is the same as at the end of FILL.
    - No accepted beat with cnt!=0: all strobes low, everything holds (stall).
    - No beat with cnt==0: go to DRAIN, cnt<=0.
  - DRAIN:
    - din_ready=0. Drives sr_valid=1, sr_pop=1, sr_din=0 for REG_DEPTH cycles, then returns to IDLE.
    - din_valid is ignored throughout DRAIN.
- Output path (one register stage):
  - On any cycle with sr_pop=1, in the next cycle:
    - dout_valid=1.
    - dout_x = sr_dout_x <<< hold_exp; no overflow is possible by construction.
    - blk_exp = hold_exp.
    - dout_last=1 for the REG_DEPTH-th beat of the read block.
  - On cycles without sr_pop, dout_valid=0 and dout_i/dout_q/blk_exp hold their last value.
  - hold_exp must not change until the read block's last beat has been popped. The handoff above coincides with that beat, so the new value takes effect from the next block's first pop.
- Latency:
  - Beat n of block k leaves one cycle after beat n of block k+1 is accepted (or after drain cycle n).
  - Minimum latency is REG_DEPTH+1 cycles.
- Output order equals input order.

Decomposition:
- Shared package `cbfp_pkg`: state enum {IDLE, FILL, STREAM, DRAIN}; EXP_WIDTH derivation function; lane sample typedef.
- Sub-module `cbfp_sign_cnt`: combinational per-sample redundant-sign count. It is instanced 2*NUM_IN_OUT times and feeds a min-reduction tree in the top module.

Test Plan:
- All samples = 1 over one block, then idle -> FILL 16 cycles, DRAIN 16 cycles; 16 output beats with every lane = 128, blk_exp=7, dout_last on beat 16; return to IDLE.
- Block 0 all -256, block 1 all 63 back-to-back -> block 0 outputs -256 with blk_exp=0; block 1 outputs 252 with blk_exp=2; exponent switches exactly on the first pop of block 1; sr_pop never high without sr_valid.
- Block of zeros except one Q sample = 127 in beat 9, lane 5 -> blk_exp=1; that sample outputs 254; all others output 0.
- Stall: drop din_valid for 3 cycles at cnt=7 in STREAM -> sr_valid=sr_pop=0 for those 3 cycles, no dout_valid, no data lost; order preserved.
- DRAIN with din_valid=1 -> din_ready=0 for 16 cycles, no beat accepted; IDLE accepts on the 17th cycle.
- rstn=0 for 1 cycle mid-STREAM (cnt=10) -> next cycle state IDLE, dout_valid=0, blk_exp=0; a new block afterwards normalises correctly.
